// File: rtl/nvdla_cacc_dlv_pkg.sv
// Shared definitions for the CACC delivery buffer pipe: SDP payload flag
// positions, the per-entry metadata record and FIFO sizing helpers.
package nvdla_cacc_dlv_pkg;

   // Flag positions in sdp_pd, counted from the first bit above the data field.
   localparam int BATCH_END_BIT = 0;
   localparam int LAYER_END_BIT = 1;

   // Wide enough for any practical slice count; the normalised value is 1..SLICES.
   localparam int META_NSLICE_W = 8;

   // Metadata carried alongside each RAM entry through the pipe and FIFO.
   typedef struct packed {
      logic [META_NSLICE_W-1:0] nslice;
      logic                     layer_end;
   } meta_t;

   // Entries that can be outstanding at once: all reads in flight plus two
   // staged entries, which is what keeps nslice=1 traffic bubble-free.
   function automatic int fifo_depth(input int ram_lat);
      return ram_lat + 2;
   endfunction

   // Width of a counter that must hold values 0..n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/nvdla_cacc_dlv_fifo.sv
// Small synchronous flop FIFO with a combinational head view. Push and pop
// in the same cycle are allowed; pushes into a full FIFO are dropped unless
// a pop frees the slot in the same cycle.
module nvdla_cacc_dlv_fifo
#(
   parameter int DEPTH = 3,
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
)
(
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop & (count_reg != '0);
   assign do_push = push & ((count_reg != CNT_W'(DEPTH)) | do_pop);

   assign head  = mem_reg[rd_ptr_reg];
   assign count = count_reg;
   assign empty = (count_reg == '0);

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/nvdla_cacc_dlv_buf_pipe.sv
// CACC delivery buffer pipe: issues entry reads to the delivery RAM, stages
// returned entries in a FIFO, slices each entry into SDP beats, and returns
// batched credits plus ping-pong layer-done pulses.
module nvdla_cacc_dlv_buf_pipe
   import nvdla_cacc_dlv_pkg::*;
#(
   parameter int DBUF_AWIDTH  = 5,
   parameter int SDP_DWIDTH   = 512,
   parameter int SLICES       = 4,
   parameter int RAM_LAT      = 1,
   parameter int CREDIT_W     = 3,
   parameter int CREDIT_BATCH = 1
)
(
   input  logic                           nvdla_core_clk,
   input  logic                           nvdla_core_rst,
   input  logic                           rd_req_valid,
   output logic                           rd_req_ready,
   input  logic [DBUF_AWIDTH-1:0]         rd_req_addr,
   input  logic [$clog2(SLICES+1)-1:0]    rd_req_nslice,
   input  logic                           rd_req_layer_end,
   output logic                           ram_re,
   output logic [DBUF_AWIDTH-1:0]         ram_ra,
   input  logic [SLICES*SDP_DWIDTH-1:0]   ram_rdata,
   output logic                           sdp_valid,
   input  logic                           sdp_ready,
   output logic [SDP_DWIDTH+1:0]          sdp_pd,
   output logic                           credit_vld,
   output logic [CREDIT_W-1:0]            credit_size,
   output logic [1:0]                     done_intr_pd
);

   localparam int FIFO_DEPTH = fifo_depth(RAM_LAT);
   localparam int CNT_W      = cnt_width(FIFO_DEPTH);
   localparam int OCC_W      = cnt_width(FIFO_DEPTH + RAM_LAT);
   localparam int RAM_W      = SLICES * SDP_DWIDTH;
   localparam int META_W     = $bits(meta_t);
   localparam int ENTRY_W    = RAM_W + META_W;
   localparam int SP_W       = (SLICES > 1) ? $clog2(SLICES) : 1;

   logic                   ready_en_reg;
   logic                   accept;
   logic [DBUF_AWIDTH-1:0] ra_reg;
   meta_t                  req_meta;

   logic                   pipe_vld_reg  [RAM_LAT];
   meta_t                  pipe_meta_reg [RAM_LAT];
   logic [OCC_W-1:0]       inflight;
   logic [OCC_W-1:0]       occ;

   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;
   logic [ENTRY_W-1:0]     fifo_wdata;
   logic [ENTRY_W-1:0]     fifo_head;

   meta_t                  head_meta;
   logic [RAM_W-1:0]       head_data;
   logic [SDP_DWIDTH-1:0]  slice_data [SLICES];
   logic [SDP_DWIDTH-1:0]  beat_data;
   logic [SP_W-1:0]        sptr_reg;
   logic                   last_beat;
   logic                   beat;

   logic [CREDIT_W-1:0]    cnt_reg;
   logic [CREDIT_W-1:0]    cnt_inc;
   logic                   credit_vld_reg;
   logic [CREDIT_W-1:0]    credit_size_reg;
   logic                   intr_sel_reg;
   logic [1:0]             done_reg;

   // ------------------------------------------------------------------
   // Request side
   // ------------------------------------------------------------------

   // Hold ready low through reset and release it on the first cycle after.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         ready_en_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
      end
   end

   // Count reads still travelling through the RAM latency pipe.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RAM_LAT; i++) begin
         inflight = inflight + OCC_W'(pipe_vld_reg[i]);
      end
   end

   // Reserving FIFO space for every in-flight read means the FIFO cannot
   // overflow, and ready never depends on sdp_ready.
   assign occ          = OCC_W'(fifo_count) + inflight;
   assign rd_req_ready = ready_en_reg & (occ < OCC_W'(FIFO_DEPTH));
   assign accept       = rd_req_valid & rd_req_ready;
   assign ram_re       = accept;
   assign ram_ra       = accept ? rd_req_addr : ra_reg;

   // Keep the last issued address on ram_ra between reads.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         ra_reg <= '0;
      end else if (accept) begin
         ra_reg <= rd_req_addr;
      end
   end

   // Normalise nslice: zero or out-of-range means a full entry.
   always_comb begin
      req_meta.layer_end = rd_req_layer_end;
      req_meta.nslice    = META_NSLICE_W'(rd_req_nslice);
      if ((rd_req_nslice == '0) || (32'(rd_req_nslice) > SLICES)) begin
         req_meta.nslice = META_NSLICE_W'(SLICES);
      end
   end

   // Metadata shift register aligned with the RAM read latency.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            pipe_vld_reg[i]  <= 1'b0;
            pipe_meta_reg[i] <= '0;
         end
      end else begin
         pipe_vld_reg[0]  <= accept;
         pipe_meta_reg[0] <= req_meta;
         for (int i = 1; i < RAM_LAT; i++) begin
            pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
            pipe_meta_reg[i] <= pipe_meta_reg[i-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Staging FIFO
   // ------------------------------------------------------------------

   assign fifo_push  = pipe_vld_reg[RAM_LAT-1];
   assign fifo_wdata = {pipe_meta_reg[RAM_LAT-1], ram_rdata};

   nvdla_cacc_dlv_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (nvdla_core_clk),
      .srst  (nvdla_core_rst),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Slicing and SDP output
   // ------------------------------------------------------------------

   assign head_meta = meta_t'(fifo_head[ENTRY_W-1:RAM_W]);
   assign head_data = fifo_head[RAM_W-1:0];

   for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
      assign slice_data[gi] = head_data[gi*SDP_DWIDTH +: SDP_DWIDTH];
   end

   assign beat_data = slice_data[sptr_reg];
   assign last_beat = (META_NSLICE_W'(sptr_reg) == (head_meta.nslice - META_NSLICE_W'(1)));
   assign sdp_valid = ~fifo_empty;
   assign beat      = sdp_valid & sdp_ready;
   assign fifo_pop  = beat & last_beat;

   // Payload is forced to zero when no beat is presented.
   always_comb begin
      sdp_pd = '0;
      if (sdp_valid) begin
         sdp_pd[SDP_DWIDTH-1:0]            = beat_data;
         sdp_pd[SDP_DWIDTH+LAYER_END_BIT]  = head_meta.layer_end & last_beat;
         sdp_pd[SDP_DWIDTH+BATCH_END_BIT]  = 1'b0;
      end
   end

   // Slice pointer walks the head entry and rewinds when it is popped.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         sptr_reg <= '0;
      end else if (beat) begin
         if (last_beat) begin
            sptr_reg <= '0;
         end else begin
            sptr_reg <= sptr_reg + SP_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Credit and layer-done reporting
   // ------------------------------------------------------------------

   assign cnt_inc = cnt_reg + CREDIT_W'(1);

   // Batch popped entries into credits; a layer end flushes a partial batch.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         cnt_reg         <= '0;
         credit_vld_reg  <= 1'b0;
         credit_size_reg <= '0;
      end else begin
         credit_vld_reg  <= 1'b0;
         credit_size_reg <= '0;
         if (fifo_pop) begin
            if ((cnt_inc == CREDIT_W'(CREDIT_BATCH)) || head_meta.layer_end) begin
               credit_vld_reg  <= 1'b1;
               credit_size_reg <= cnt_inc;
               cnt_reg         <= '0;
            end else begin
               cnt_reg <= cnt_inc;
            end
         end
      end
   end

   // Alternate the layer-done pulse between the two interrupt lines.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         intr_sel_reg <= 1'b0;
         done_reg     <= 2'b00;
      end else begin
         done_reg <= 2'b00;
         if (fifo_pop && head_meta.layer_end) begin
            done_reg     <= intr_sel_reg ? 2'b10 : 2'b01;
            intr_sel_reg <= ~intr_sel_reg;
         end
      end
   end

   assign credit_vld   = credit_vld_reg;
   assign credit_size  = credit_size_reg;
   assign done_intr_pd = done_reg;

endmodule

// File: tb/tb_nvdla_cacc_dlv_buf_pipe.sv
// Directed bench for the delivery buffer pipe. Instance A uses RAM_LAT=1 and
// single-entry credits; instance B uses RAM_LAT=2 and batches of four.
module tb_nvdla_cacc_dlv_buf_pipe;

   localparam int DW = 8;

   logic          clk;
   logic          rst;

   logic          valid_a, ready_a, le_a, re_a, sv_a, srdy_a, cv_a;
   logic [4:0]    addr_a, ra_a;
   logic [2:0]    ns_a, cs_a;
   logic [31:0]   rdata_a;
   logic [DW+1:0] pd_a;
   logic [1:0]    done_a;

   logic          valid_b, ready_b, le_b, re_b, sv_b, srdy_b, cv_b;
   logic [4:0]    addr_b, ra_b;
   logic [2:0]    ns_b, cs_b;
   logic [31:0]   rdata_b;
   logic [DW+1:0] pd_b;
   logic [1:0]    done_b;

   logic [4:0]    ra_a_d1, ra_b_d1, ra_b_d2;

   int n_cmp;
   int n_err;

   nvdla_cacc_dlv_buf_pipe #(
      .DBUF_AWIDTH(5), .SDP_DWIDTH(DW), .SLICES(4),
      .RAM_LAT(1), .CREDIT_W(3), .CREDIT_BATCH(1)
   ) dut_a (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst),
      .rd_req_valid(valid_a), .rd_req_ready(ready_a), .rd_req_addr(addr_a),
      .rd_req_nslice(ns_a), .rd_req_layer_end(le_a),
      .ram_re(re_a), .ram_ra(ra_a), .ram_rdata(rdata_a),
      .sdp_valid(sv_a), .sdp_ready(srdy_a), .sdp_pd(pd_a),
      .credit_vld(cv_a), .credit_size(cs_a), .done_intr_pd(done_a)
   );

   nvdla_cacc_dlv_buf_pipe #(
      .DBUF_AWIDTH(5), .SDP_DWIDTH(DW), .SLICES(4),
      .RAM_LAT(2), .CREDIT_W(3), .CREDIT_BATCH(4)
   ) dut_b (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst),
      .rd_req_valid(valid_b), .rd_req_ready(ready_b), .rd_req_addr(addr_b),
      .rd_req_nslice(ns_b), .rd_req_layer_end(le_b),
      .ram_re(re_b), .ram_ra(ra_b), .ram_rdata(rdata_b),
      .sdp_valid(sv_b), .sdp_ready(srdy_b), .sdp_pd(pd_b),
      .credit_vld(cv_b), .credit_size(cs_b), .done_intr_pd(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM content: slice s of address a holds {a[3:0], s[3:0]}.
   function automatic logic [31:0] mk(input logic [4:0] a);
      logic [31:0] r;
      for (int s = 0; s < 4; s++) r[s*8 +: 8] = {a[3:0], 4'(s)};
      return r;
   endfunction

   // Expected SDP payload {layer_end, batch_end, data}.
   function automatic logic [9:0] epd(input logic le, input logic [4:0] a, input logic [1:0] s);
      return {le, 1'b0, a[3:0], 2'b00, s};
   endfunction

   // RAM models with one and two cycles of read latency.
   always @(posedge clk) begin
      ra_a_d1 <= ra_a;
      ra_b_d1 <= ra_b;
      ra_b_d2 <= ra_b_d1;
   end
   assign rdata_a = mk(ra_a_d1);
   assign rdata_b = mk(ra_b_d2);

   // One line per delivered beat.
   always @(negedge clk) begin
      if (!rst && sv_a && srdy_a) $display("[%0t] beat A pd=%h", $time, pd_a);
      if (!rst && sv_b && srdy_b) $display("[%0t] beat B pd=%h", $time, pd_b);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic drv_a(input logic v, input logic [4:0] a, input logic [2:0] ns,
                        input logic le, input logic rdy);
      valid_a = v; addr_a = a; ns_a = ns; le_a = le; srdy_a = rdy;
   endtask

   task automatic drv_b(input logic v, input logic [4:0] a, input logic [2:0] ns,
                        input logic le, input logic rdy);
      valid_b = v; addr_b = a; ns_b = ns; le_b = le; srdy_b = rdy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      drv_a(0, 0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0);

      // Reset state
      tick(); tick(); tick();
      settle();
      chk("rst_ready_a", ready_a, 0);
      chk("rst_ready_b", ready_b, 0);
      chk("rst_valid_a", sv_a, 0);
      chk("rst_pd_a", pd_a, 0);
      chk("rst_ram_re_a", re_a, 0);
      chk("rst_ram_ra_a", ra_a, 0);
      chk("rst_credit_a", cv_a, 0);
      chk("rst_done_b", done_b, 0);
      tick();
      rst = 1'b0;
      settle();
      chk("rel_ready_a_same", ready_a, 0);
      tick();
      settle();
      chk("rel_ready_a_next", ready_a, 1);
      chk("rel_ready_b_next", ready_b, 1);

      // A: single request addr=3 nslice=4, beats at t+2..t+5, credit at t+6
      for (int i = 0; i < 8; i++) begin
         tick();
         drv_a(i == 0, 5'd3, 3'd4, 0, 1);
         settle();
         if (i == 0) begin
            chk("a1_ready", ready_a, 1);
            chk("a1_ram_re", re_a, 1);
            chk("a1_ram_ra", ra_a, 3);
         end
         if (i == 1) begin
            chk("a1_ram_re_off", re_a, 0);
            chk("a1_ram_ra_hold", ra_a, 3);
         end
         if (i >= 2 && i <= 5) begin
            chk("a1_valid", sv_a, 1);
            chk("a1_pd", pd_a, epd(0, 5'd3, 2'(i - 2)));
         end else begin
            chk("a1_idle", sv_a, 0);
         end
         chk("a1_credit", cv_a, (i == 6));
         if (i == 6) chk("a1_credit_size", cs_a, 1);
         chk("a1_done", done_a, 0);
      end

      // B: eight back-to-back nslice=1 requests, continuous output
      for (int i = 0; i < 12; i++) begin
         tick();
         drv_b(i < 8, 5'(i), 3'd1, 0, 1);
         settle();
         if (i < 8) chk("b_thru_ready", ready_b, 1);
         if (i >= 3 && i <= 10) begin
            chk("b_thru_valid", sv_b, 1);
            chk("b_thru_pd", pd_b, epd(0, 5'(i - 3), 2'd0));
         end else begin
            chk("b_thru_idle", sv_b, 0);
         end
         chk("b_thru_credit", cv_b, (i == 7 || i == 11));
         if (i == 7 || i == 11) chk("b_thru_credit_size", cs_b, 4);
      end

      // B: backpressure, four accepts then ready drops; drain in order
      for (int i = 0; i < 17; i++) begin
         tick();
         drv_b(i < 8, (i < 4) ? 5'(8 + i) : 5'd12, 3'd2, 0, i >= 8);
         settle();
         if (i <= 8) chk("b_bp_ready", ready_b, (i < 4));
         if (i < 8) chk("b_bp_ram_re", re_b, (i < 4));
         if (i >= 3 && i <= 7) begin
            chk("b_bp_stall_valid", sv_b, 1);
            chk("b_bp_stall_pd", pd_b, epd(0, 5'd8, 2'd0));
         end
         if (i >= 8 && i <= 15) begin
            chk("b_bp_drain_valid", sv_b, 1);
            chk("b_bp_drain_pd", pd_b, epd(0, 5'(8 + (i - 8) / 2), 2'((i - 8) % 2)));
         end
         if (i == 15) chk("b_bp_credit_early", cv_b, 0);
         if (i == 16) begin
            chk("b_bp_empty", sv_b, 0);
            chk("b_bp_credit", cv_b, 1);
            chk("b_bp_credit_size", cs_b, 4);
         end
      end

      // B: six entries, last with layer_end -> credit 4 then 2, done 01
      for (int i = 0; i < 11; i++) begin
         tick();
         drv_b(i < 6, 5'(i), 3'd1, i == 5, 1);
         settle();
         if (i >= 3 && i <= 8) begin
            chk("b_le_valid", sv_b, 1);
            chk("b_le_pd", pd_b, epd(i == 8, 5'(i - 3), 2'd0));
         end else begin
            chk("b_le_idle", sv_b, 0);
         end
         chk("b_le_credit", cv_b, (i == 7 || i == 9));
         if (i == 7) chk("b_le_credit_size4", cs_b, 4);
         if (i == 9) chk("b_le_credit_size2", cs_b, 2);
         chk("b_le_done", done_b, (i == 9) ? 2'b01 : 2'b00);
      end

      // B: second layer end toggles to the other interrupt line
      for (int i = 0; i < 6; i++) begin
         tick();
         drv_b(i == 0, 5'd6, 3'd1, 1, 1);
         settle();
         if (i == 3) chk("b_le2_pd", pd_b, epd(1, 5'd6, 2'd0));
         chk("b_le2_credit", cv_b, (i == 4));
         if (i == 4) chk("b_le2_credit_size", cs_b, 1);
         chk("b_le2_done", done_b, (i == 4) ? 2'b10 : 2'b00);
      end

      // A: nslice=0 and nslice=7 both deliver four beats
      for (int i = 0; i < 11; i++) begin
         tick();
         if (i == 0)      drv_a(1, 5'd4, 3'd0, 0, 1);
         else if (i == 1) drv_a(1, 5'd5, 3'd7, 1, 1);
         else             drv_a(0, 5'd0, 3'd0, 0, 1);
         settle();
         if (i <= 1) chk("a_ns_ready", ready_a, 1);
         if (i >= 2 && i <= 9) begin
            chk("a_ns_valid", sv_a, 1);
            chk("a_ns_pd", pd_a, epd(i == 9, (i < 6) ? 5'd4 : 5'd5, 2'((i - 2) % 4)));
         end else begin
            chk("a_ns_idle", sv_a, 0);
         end
         chk("a_ns_credit", cv_a, (i == 6 || i == 10));
         if (i == 6 || i == 10) chk("a_ns_credit_size", cs_a, 1);
         chk("a_ns_done", done_a, (i == 10) ? 2'b01 : 2'b00);
      end

      // B: reset with two reads in flight and one FIFO entry
      for (int i = 0; i < 3; i++) begin
         tick();
         drv_b(1, 5'(1 + i), 3'd4, 1, 0);
         settle();
         chk("b_rst_fill_ready", ready_b, 1);
      end
      tick();
      drv_b(0, 5'd0, 3'd0, 0, 0);
      rst = 1'b1;
      settle();
      chk("b_rst_pre_valid", sv_b, 1);
      tick();
      settle();
      chk("b_rst_in_valid", sv_b, 0);
      chk("b_rst_in_ready", ready_b, 0);
      tick();
      rst = 1'b0;
      srdy_b = 1'b1;
      settle();
      chk("b_rst_rel_ready_same", ready_b, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         settle();
         chk("b_rst_after_ready", ready_b, 1);
         chk("b_rst_after_valid", sv_b, 0);
         chk("b_rst_after_credit", cv_b, 0);
         chk("b_rst_after_done", done_b, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
